// File: rtl/onewire_master_engine_if.sv
// Command/response handshake and open-drain line signals of the 1-Wire master engine.
// The engine connects through the slave modport; the host and line model use master.
interface onewire_master_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       busy;
  logic       owr_oe;
  logic       owr_i;

  modport master (
    output cmd_valid, cmd_op, cmd_data, owr_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_presence, busy, owr_oe
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, owr_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_presence, busy, owr_oe
  );
endinterface

// File: rtl/onewire_master_engine.sv
// Byte-level 1-Wire master: reset/presence, write-byte and read-byte slot timing on an
// open-drain line. Define ONEWIRE_OVERDRIVE_EN to add the per-command ovd tick-rate input.
module onewire_master_engine #(
    parameter int TICK_DIV   = 10,
    parameter int T_RSTL     = 96,
    parameter int T_RSTH     = 96,
    parameter int T_PDS      = 14,
    parameter int T_SLOT     = 12,
    parameter int T_LOW1     = 1,
    parameter int T_LOW0     = 12,
    parameter int T_SAMP     = 3,
    parameter int T_REC      = 1,
    parameter int TICK_DIV_O = 2
) (
    input logic                   clk,
    input logic                   arst_n,
`ifdef ONEWIRE_OVERDRIVE_EN
    input logic                   ovd,
`endif
    onewire_master_engine_if.slave bus
);

    localparam int T_MAX_A = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
    localparam int T_MAX   = (T_MAX_A > T_SLOT) ? T_MAX_A : T_SLOT;
    localparam int CNT_W   = $clog2(T_MAX + 1);
    localparam int DIV_MAX = (TICK_DIV > TICK_DIV_O) ? TICK_DIV : TICK_DIV_O;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [CNT_W-1:0] C_RSTL = CNT_W'(T_RSTL);
    localparam logic [CNT_W-1:0] C_RSTH = CNT_W'(T_RSTH);
    localparam logic [CNT_W-1:0] C_PDS  = CNT_W'(T_PDS);
    localparam logic [CNT_W-1:0] C_SLOT = CNT_W'(T_SLOT);
    localparam logic [CNT_W-1:0] C_LOW1 = CNT_W'(T_LOW1);
    localparam logic [CNT_W-1:0] C_LOW0 = CNT_W'(T_LOW0);
    localparam logic [CNT_W-1:0] C_SAMP = CNT_W'(T_SAMP);
    localparam logic [CNT_W-1:0] C_REC  = CNT_W'(T_REC);

    typedef enum logic [1:0] {OP_RESET = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_NOP = 2'b11} op_e;
    typedef enum logic [2:0] {S_IDLE, S_RST_LOW, S_RST_HIGH, S_SLOT_LOW, S_SLOT_HIGH, S_REC, S_DONE} state_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         sync_q, sync_d;
    logic               pres_q, pres_d;
    logic               owr_oe_q, owr_oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_pres_q, rsp_pres_d;
`ifdef ONEWIRE_OVERDRIVE_EN
    logic               ovd_q, ovd_d;
`endif

    logic               tick;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   low_len;
    logic [DIV_W-1:0]   div_top;

`ifdef ONEWIRE_OVERDRIVE_EN
    assign div_top = ovd_q ? DIV_W'(TICK_DIV_O - 1) : DIV_W'(TICK_DIV - 1);
`else
    assign div_top = DIV_W'(TICK_DIV - 1);
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        pres_d      = pres_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_pres_d  = rsp_pres_q;
        sync_d      = {sync_q[0], bus.owr_i};
`ifdef ONEWIRE_OVERDRIVE_EN
        ovd_d       = ovd_q;
`endif
        tick        = (div_q == div_top);
        cnt_inc     = cnt_q + 1'b1;
        low_len     = (op_q == OP_READ || data_q[bit_q]) ? C_LOW1 : C_LOW0;

        if (state_q != S_IDLE) div_d = tick ? '0 : div_q + 1'b1;

        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                op_d    = op_e'(bus.cmd_op);
                data_d  = bus.cmd_data;
                shift_d = '0;
                bit_d   = '0;
                cnt_d   = '0;
                div_d   = '0;
                pres_d  = 1'b0;
`ifdef ONEWIRE_OVERDRIVE_EN
                ovd_d   = ovd;
`endif
                unique case (op_e'(bus.cmd_op))
                    OP_RESET:          state_d = S_RST_LOW;
                    OP_WRITE, OP_READ: state_d = S_SLOT_LOW;
                    default:           state_d = S_DONE;
                endcase
            end
            S_RST_LOW: if (tick) begin
                cnt_d = cnt_inc;
                if (cnt_inc == C_RSTL) begin
                    state_d = S_RST_HIGH;
                    cnt_d   = '0;
                end
            end
            S_RST_HIGH: if (tick) begin
                cnt_d = cnt_inc;
                if (cnt_inc == C_PDS) pres_d = ~sync_q[1];
                if (cnt_inc == C_RSTH) state_d = S_DONE;
            end
            // Slot tick count runs from the falling edge through both slot phases.
            S_SLOT_LOW: if (tick) begin
                cnt_d = cnt_inc;
                if (cnt_inc == low_len) begin
                    if (low_len >= C_SLOT) begin
                        state_d = S_REC;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_SLOT_HIGH;
                    end
                end
            end
            S_SLOT_HIGH: if (tick) begin
                cnt_d = cnt_inc;
                if (op_q == OP_READ && cnt_inc == C_SAMP) shift_d[bit_q] = sync_q[1];
                if (cnt_inc == C_SLOT) begin
                    state_d = S_REC;
                    cnt_d   = '0;
                end
            end
            S_REC: if (tick) begin
                cnt_d = cnt_inc;
                if (cnt_inc == C_REC) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = S_SLOT_LOW;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        owr_oe_d = (state_d == S_RST_LOW) || (state_d == S_SLOT_LOW);

        if (state_d == S_DONE && state_q != S_DONE) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = (op_d == OP_READ)  ? shift_q : 8'h00;
            rsp_pres_d  = (op_d == OP_RESET) ? pres_q  : 1'b0;
        end
    end

    // NOTE: the reset is asynchronous and active-high despite its name, so the line releases without a clock.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            sync_q      <= 2'b11;
            pres_q      <= 1'b0;
            owr_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_pres_q  <= 1'b0;
`ifdef ONEWIRE_OVERDRIVE_EN
            ovd_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            sync_q      <= sync_d;
            pres_q      <= pres_d;
            owr_oe_q    <= owr_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_pres_q  <= rsp_pres_d;
`ifdef ONEWIRE_OVERDRIVE_EN
            ovd_q       <= ovd_d;
`endif
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.owr_oe       = owr_oe_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_presence = rsp_pres_q;

endmodule

// File: tb/tb_onewire_master_engine.sv
// Scoreboard bench for onewire_master_engine: directed commands push expected responses
// and low-phase widths; monitors on the response strobe and on owr_oe pop and compare.
module tb_onewire_master_engine;

    typedef struct {
        logic [7:0] data;
        logic       pres;
        int         lat;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n;
`ifdef ONEWIRE_OVERDRIVE_EN
    logic ovd;
`endif
    onewire_master_engine_if bus ();

    onewire_master_engine dut (
        .clk    (clk),
        .arst_n (arst_n),
`ifdef ONEWIRE_OVERDRIVE_EN
        .ovd    (ovd),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Open-drain line: master or slave pulls low, pull-up otherwise.
    logic slave_pull;
    assign bus.owr_i = !(bus.owr_oe || slave_pull);

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rsp_count = 0;
    exp_t exp_q[$];
    int   exp_low[$];
    bit   check_lows = 1'b1;
    int   slave_mode = 0;       // 0 pull-up only, 1 presence responder, 2 read responder
    logic [7:0] slave_byte = 8'h00;
    int   slave_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: latency counts clocks from the accepting edge to the sampling edge of rsp_valid.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data %0h presence %0b with nothing pending", bus.rsp_data, bus.rsp_presence);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                check("rsp_presence", 32'(bus.rsp_presence), 32'(e.pres));
                check("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                check("busy_in_rsp", 32'(bus.busy), 32'd1);
            end
        end
    end

    // Slave model plus low-phase width monitor on owr_oe.
    initial begin
        int t0;
        int width;
        bit drive0;
        slave_pull = 1'b0;
        forever begin
            @(posedge bus.owr_oe);
            t0 = int'($time);
            drive0 = (slave_mode == 2) && !slave_byte[slave_idx[2:0]];
            slave_idx++;
            if (drive0) slave_pull = 1'b1;
            @(negedge bus.owr_oe);
            width = (int'($time) - t0) / 10;
            if (check_lows) begin
                if (exp_low.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_low: got low phase of %0d clks with none expected", width);
                end else begin
                    check("low_width", 32'(width), 32'(exp_low.pop_front()));
                end
            end
            if (drive0) begin
                repeat (30) @(posedge clk);
                slave_pull = 1'b0;
            end
            if (slave_mode == 1 && width >= 400) begin
                repeat (30) @(posedge clk);
                slave_pull = 1'b1;
                repeat (120) @(posedge clk);
                slave_pull = 1'b0;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] data, input logic [7:0] ed,
                        input logic ep, input int lat, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        if (push) exp_q.push_back('{data: ed, pres: ep, lat: lat, acc: cyc + 1});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.busy || exp_q.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
        check({name, "_rsp_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_lows_pending"}, 32'(exp_low.size()), 32'd0);
    endtask

    task automatic push_byte_lows(input logic [7:0] b, input int lo1, input int lo0);
        for (int i = 0; i < 8; i++) exp_low.push_back(b[i] ? lo1 : lo0);
    endtask

    initial begin
        int n;
        int base;
        arst_n        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b11;
        bus.cmd_data  = 8'h00;
`ifdef ONEWIRE_OVERDRIVE_EN
        ovd = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_owr_oe", 32'(bus.owr_oe), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_presence", 32'(bus.rsp_presence), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        arst_n = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Reset pulse with a slave answering presence.
        slave_mode = 1;
        exp_low.push_back(960);
        send(2'b00, 8'h00, 8'h00, 1'b1, 1921, 1'b1);
        wait_done("t1_presence");

        // Reset pulse with only the pull-up on the line.
        slave_mode = 0;
        exp_low.push_back(960);
        send(2'b00, 8'h00, 8'h00, 1'b0, 1921, 1'b1);
        wait_done("t2_no_presence");

        // No-op: immediate response, no bus activity.
        send(2'b11, 8'hFF, 8'h00, 1'b0, 1, 1'b1);
        wait_done("noop");

        // Write 0xA5, LSB first.
        push_byte_lows(8'hA5, 10, 120);
        send(2'b01, 8'hA5, 8'h00, 1'b0, 1041, 1'b1);
        wait_done("t3_write_a5");

        // Read bytes driven by the slave; every read slot low is a single tick.
        slave_mode = 2;
        slave_byte = 8'h55;
        slave_idx  = 0;
        for (int i = 0; i < 8; i++) exp_low.push_back(10);
        send(2'b10, 8'h00, 8'h55, 1'b0, 1041, 1'b1);
        wait_done("t4_read_55");

        slave_byte = 8'hF0;
        slave_idx  = 0;
        for (int i = 0; i < 8; i++) exp_low.push_back(10);
        send(2'b10, 8'h00, 8'hF0, 1'b0, 1041, 1'b1);
        wait_done("read_f0");
        slave_mode = 0;

        // cmd_valid held with changing fields during a write: only the first is taken.
        base = rsp_count;
        push_byte_lows(8'h3C, 10, 120);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_data  = 8'h3C;
        exp_q.push_back('{data: 8'h00, pres: 1'b0, lat: 1041, acc: cyc + 1});
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bus.cmd_op   = 2'(i);
            bus.cmd_data = 8'(i * 7);
            if (i % 250 == 100) check("t5_ready_while_busy", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        wait_done("t5_hold_valid");
        check("t5_rsp_count", 32'(rsp_count - base), 32'd1);

`ifdef ONEWIRE_OVERDRIVE_EN
        // Overdrive write of 0x00: every low phase is 12 ticks of 2 clks.
        ovd = 1'b1;
        push_byte_lows(8'h00, 2, 24);
        send(2'b01, 8'h00, 8'h00, 1'b0, 209, 1'b1);
        ovd = 1'b0;
        wait_done("t7_overdrive");
`endif

        // Reset pulse in the middle of a write-0 low phase.
        check_lows = 1'b0;
        base = rsp_count;
        send(2'b01, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        n = 0;
        while (!bus.owr_oe && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (50) @(posedge clk);
        check("t6_oe_before_reset", 32'(bus.owr_oe), 32'd1);
        #3 arst_n = 1'b1;
        #1;
        check("t6_oe_released", 32'(bus.owr_oe), 32'd0);
        check("t6_busy_cleared", 32'(bus.busy), 32'd0);
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #3 arst_n = 1'b0;
        repeat (1500) @(negedge clk);
        check("t6_no_rsp", 32'(rsp_count - base), 32'd0);
        check("t6_idle_ready", 32'(bus.cmd_ready), 32'd1);
        check("t6_rsp_data_cleared", 32'(bus.rsp_data), 32'd0);
        exp_low.delete();
        check_lows = 1'b1;

        // Engine accepts work again after the reset.
        send(2'b11, 8'h00, 8'h00, 1'b0, 1, 1'b1);
        wait_done("post_reset_noop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
